// File: rtl/mbc_bank_ctrl.sv
// mbc_bank_ctrl: cartridge memory bank controller (MBC5-style wide ROM
// banking, optional MBC1 bank-zero compatibility).
// Register writes commit on the falling edge of the CPU write strobe.
// Reads are translated combinationally into ROM/RAM addresses and selects.
// Define RTC_EN to build in the MBC3-style real-time clock.
module mbc_bank_ctrl #(
  parameter int ROM_BANK_BITS = 9,
  parameter int RAM_BANK_BITS = 4,
  parameter int MBC1_COMPAT   = 0,
  localparam int OW = ((14 + ROM_BANK_BITS) > (13 + RAM_BANK_BITS)) ?
                      (14 + ROM_BANK_BITS) : (13 + RAM_BANK_BITS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   iadr,
  input  logic [7:0]    data,
  input  logic          write,
  input  logic          rtc_tick,
  output logic [OW-1:0] oadr,
  output logic          sel_rom,
  output logic          sel_ram,
  output logic          sel_rtc,
  output logic [7:0]    rtc_dout
);

  logic                     write_q;
  logic [ROM_BANK_BITS-1:0] rom_bank_q, rom_bank_d;
  logic [3:0]               ram_raw_q, ram_raw_d;
  logic                     ena_ram_q, ena_ram_d;

  logic commit;
  logic wr_ena, wr_rom_lo, wr_rom_hi, wr_ram, wr_latch, wr_ext;
  logic rtc_bank;

  logic [ROM_BANK_BITS-1:0] eff_bank;
  logic [RAM_BANK_BITS-1:0] ram_bank;
  logic                     rom_c, ram_c, rtc_c;

  // One commit per strobe: falling edge of the level write signal.
  assign commit    = write_q & ~write;
  assign wr_ena    = commit && (iadr[15:13] == 3'b000);
  assign wr_rom_lo = commit && (iadr[15:12] == 4'h2);
  assign wr_rom_hi = commit && (iadr[15:12] == 4'h3);
  assign wr_ram    = commit && (iadr[15:13] == 3'b010);
  assign wr_latch  = commit && (iadr[15:13] == 3'b011);
  assign wr_ext    = commit && (iadr[15:13] == 3'b101);

  // Bank register next-state; bits beyond the register width are dropped.
  always_comb begin
    rom_bank_d = rom_bank_q;
    ram_raw_d  = ram_raw_q;
    ena_ram_d  = ena_ram_q;
    for (int i = 0; i < ROM_BANK_BITS; i++) begin
      if (wr_rom_lo && (i < 8))  rom_bank_d[i] = data[i[2:0]];
      if (wr_rom_hi && (i == 8)) rom_bank_d[i] = data[0];
    end
    if (wr_ram) ram_raw_d = data[3:0];
    if (wr_ena) ena_ram_d = (data[3:0] == 4'hA);
  end

  // Bank registers and write-strobe history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q    <= 1'b0;
      rom_bank_q <= ROM_BANK_BITS'(1);
      ram_raw_q  <= 4'h0;
      ena_ram_q  <= 1'b0;
    end else begin
      write_q    <= write;
      rom_bank_q <= rom_bank_d;
      ram_raw_q  <= ram_raw_d;
      ena_ram_q  <= ena_ram_d;
    end
  end

  // The raw 4-bit RAM bank is kept so RTC register numbers decode even
  // when the RAM bank register is narrower.
  assign ram_bank = RAM_BANK_BITS'(ram_raw_q);

  // Combinational read translation; selects are forced low during reset.
  always_comb begin
    eff_bank = rom_bank_q;
    if ((MBC1_COMPAT != 0) && (rom_bank_q[4:0] == 5'd0))
      eff_bank = rom_bank_q | ROM_BANK_BITS'(1);
    oadr  = OW'(iadr);
    rom_c = 1'b0;
    ram_c = 1'b0;
    rtc_c = 1'b0;
    case (iadr[15:13])
      3'b000, 3'b001: begin
        oadr  = OW'(iadr);
        rom_c = 1'b1;
      end
      3'b010, 3'b011: begin
        oadr  = OW'({eff_bank, iadr[13:0]});
        rom_c = 1'b1;
      end
      3'b101: begin
        oadr = OW'({ram_bank, iadr[12:0]});
        if (rtc_bank) rtc_c = 1'b1;
        else          ram_c = ena_ram_q;
      end
      default: begin
        oadr = OW'(iadr);
      end
    endcase
    sel_rom = rom_c & reset_n;
    sel_ram = ram_c & reset_n;
    sel_rtc = rtc_c & reset_n;
  end

`ifdef RTC_EN
  localparam logic [0:0] LAT_IDLE  = 1'b0;
  localparam logic [0:0] LAT_ARMED = 1'b1;

  logic [5:0] rtc_s_q, rtc_s_d, rtc_m_q, rtc_m_d;
  logic [4:0] rtc_h_q, rtc_h_d;
  logic [8:0] rtc_d_q, rtc_d_d;
  logic       halt_q, halt_d, carry_q, carry_d;
  logic [5:0] sh_s_q, sh_m_q;
  logic [4:0] sh_h_q;
  logic [8:0] sh_d_q;
  logic       sh_halt_q, sh_carry_q;
  logic [0:0] lat_q, lat_d;
  logic       latch_now;
  logic       tick_pend_q, tick_pend_d;
  logic       rtc_wr, adv;

  assign rtc_bank = ena_ram_q && (ram_raw_q >= 4'h8) && (ram_raw_q <= 4'hC);
  assign rtc_wr   = wr_ext && rtc_bank;
  // A tick landing on a register write is deferred one cycle, not lost.
  assign tick_pend_d = rtc_wr && (rtc_tick || tick_pend_q);
  assign adv         = !rtc_wr && (rtc_tick || tick_pend_q) && !halt_q;

  // Live counter next-state. Out-of-range values simply count up and wrap
  // through the natural field width, which never produces a carry.
  // rtc_tick arrives already divided to 1 Hz, so there is no sub-second
  // prescale to clear on a write.
  always_comb begin
    rtc_s_d = rtc_s_q;
    rtc_m_d = rtc_m_q;
    rtc_h_d = rtc_h_q;
    rtc_d_d = rtc_d_q;
    halt_d  = halt_q;
    carry_d = carry_q;
    if (rtc_wr) begin
      case (ram_raw_q)
        4'h8:    rtc_s_d = data[5:0];
        4'h9:    rtc_m_d = data[5:0];
        4'hA:    rtc_h_d = data[4:0];
        4'hB:    rtc_d_d[7:0] = data;
        default: begin
          rtc_d_d[8] = data[0];
          halt_d     = data[6];
          carry_d    = data[7];
        end
      endcase
    end else if (adv) begin
      if (rtc_s_q == 6'd59) begin
        rtc_s_d = 6'd0;
        if (rtc_m_q == 6'd59) begin
          rtc_m_d = 6'd0;
          if (rtc_h_q == 5'd23) begin
            rtc_h_d = 5'd0;
            rtc_d_d = rtc_d_q + 9'd1;
            if (rtc_d_q == 9'd511) carry_d = 1'b1;
          end else begin
            rtc_h_d = rtc_h_q + 5'd1;
          end
        end else begin
          rtc_m_d = rtc_m_q + 6'd1;
        end
      end else begin
        rtc_s_d = rtc_s_q + 6'd1;
      end
    end
  end

  // Latch sequencer: 0x00 arms, a following 0x01 copies live to shadow.
  always_comb begin
    lat_d     = lat_q;
    latch_now = 1'b0;
    if (wr_latch) begin
      if (lat_q == LAT_IDLE) begin
        if (data == 8'h00) lat_d = LAT_ARMED;
      end else begin
        lat_d     = LAT_IDLE;
        latch_now = (data == 8'h01);
      end
    end
  end

  // RTC live counters, shadow copy and sequencer state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rtc_s_q     <= 6'd0;
      rtc_m_q     <= 6'd0;
      rtc_h_q     <= 5'd0;
      rtc_d_q     <= 9'd0;
      halt_q      <= 1'b0;
      carry_q     <= 1'b0;
      sh_s_q      <= 6'd0;
      sh_m_q      <= 6'd0;
      sh_h_q      <= 5'd0;
      sh_d_q      <= 9'd0;
      sh_halt_q   <= 1'b0;
      sh_carry_q  <= 1'b0;
      lat_q       <= LAT_IDLE;
      tick_pend_q <= 1'b0;
    end else begin
      rtc_s_q     <= rtc_s_d;
      rtc_m_q     <= rtc_m_d;
      rtc_h_q     <= rtc_h_d;
      rtc_d_q     <= rtc_d_d;
      halt_q      <= halt_d;
      carry_q     <= carry_d;
      lat_q       <= lat_d;
      tick_pend_q <= tick_pend_d;
      if (latch_now) begin
        sh_s_q     <= rtc_s_q;
        sh_m_q     <= rtc_m_q;
        sh_h_q     <= rtc_h_q;
        sh_d_q     <= rtc_d_q;
        sh_halt_q  <= halt_q;
        sh_carry_q <= carry_q;
      end
    end
  end

  // Shadow register read mux, visible only while the RTC is selected.
  always_comb begin
    rtc_dout = 8'h00;
    if (sel_rtc) begin
      case (ram_raw_q)
        4'h8:    rtc_dout = {2'b00, sh_s_q};
        4'h9:    rtc_dout = {2'b00, sh_m_q};
        4'hA:    rtc_dout = {3'b000, sh_h_q};
        4'hB:    rtc_dout = sh_d_q[7:0];
        default: rtc_dout = {sh_carry_q, sh_halt_q, 5'b00000, sh_d_q[8]};
      endcase
    end
  end
`else
  logic unused_rtc_tick;
  assign unused_rtc_tick = rtc_tick | wr_latch | wr_ext;
  assign rtc_bank        = 1'b0;
  assign rtc_dout        = 8'h00;
`endif

endmodule
